// File: rtl/sva_cover_count_sched.sv
// rtl/sva_cover_count_sched.sv - changed/stable coverage counting scheduler; optional assertions under SVA_SCHED_ASSERT_EN
module sva_cover_count_sched #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int PW  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable,
    input  logic [NCH-1:0]               sig,
    input  logic                         hold,
    input  logic                         clr,
    input  logic [$clog2(2*NCH)-1:0]     rd_addr,
    output logic [CW-1:0]                rd_data,
    output logic                         gnt_valid,
    output logic [$clog2(2*NCH)-1:0]     gnt_slot,
    output logic [NCH-1:0]               ovf,
    output logic                         busy
);

    localparam int NS = 2 * NCH;
    localparam int AW = $clog2(NS);
    localparam logic [PW-1:0] PMAX = '1;

    logic [CW-1:0]  cnt_q  [NS];
    logic [CW-1:0]  cnt_d  [NS];
    logic [PW-1:0]  pend_q [NS];
    logic [PW-1:0]  pend_d [NS];
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [NCH-1:0] prev_q, prev_d;
    logic           primed_q, primed_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  rd_data_q, rd_data_d;
    logic           gnt_valid_q, gnt_valid_d;
    logic [AW-1:0]  gnt_slot_q, gnt_slot_d;
    logic           busy_q, busy_d;

    logic [NS-1:0]  ev;
    logic           grant;
    logic [AW-1:0]  grant_slot;
    logic [AW:0]    idx;

    // Saturating fold of a pending value into a wide counter
    function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] a, input logic [PW-1:0] b);
        logic [CW:0] t;
        t = {1'b0, a} + (CW+1)'(b);
        return t[CW] ? {CW{1'b1}} : t[CW-1:0];
    endfunction

    // Classify each channel as changed (even slot) or stable (odd slot) once primed
    always_comb begin
        ev = '0;
        for (int i = 0; i < NCH; i++) begin
            ev[2*i]   = primed_q && enable && (sig[i] != prev_q[i]);
            ev[2*i+1] = primed_q && enable && (sig[i] == prev_q[i]);
        end
    end

    // Round-robin search from ptr for the first slot with pending work
    always_comb begin
        grant      = 1'b0;
        grant_slot = '0;
        idx        = '0;
        for (int k = 0; k < NS; k++) begin
            idx = {1'b0, ptr_q} + (AW+1)'(k);
            if (idx >= (AW+1)'(NS)) begin
                idx = idx - (AW+1)'(NS);
            end
            if (!grant && !hold && (pend_q[idx[AW-1:0]] != '0)) begin
                grant      = 1'b1;
                grant_slot = idx[AW-1:0];
            end
        end
    end

    // Next-state for pending, counters, flags, grant outputs and read port
    always_comb begin
        for (int s = 0; s < NS; s++) begin
            cnt_d[s]  = cnt_q[s];
            pend_d[s] = pend_q[s];
        end
        ovf_d       = ovf_q;
        prev_d      = enable ? sig : prev_q;
        primed_d    = enable;
        ptr_d       = ptr_q;
        gnt_valid_d = 1'b0;
        gnt_slot_d  = gnt_slot_q;
        busy_d      = 1'b0;
        rd_data_d   = '0;

        if ({1'b0, rd_addr} < (AW+1)'(NS)) begin
            rd_data_d = cnt_q[rd_addr];
        end

        if (clr) begin
            for (int s = 0; s < NS; s++) begin
                cnt_d[s]  = '0;
                pend_d[s] = '0;
            end
            ovf_d    = '0;
            ptr_d    = '0;
            primed_d = 1'b0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                if (grant && (grant_slot == AW'(s))) begin
                    pend_d[s] = PW'(ev[s]);
                    cnt_d[s]  = sat_add(cnt_q[s], pend_q[s]);
                end else if (ev[s]) begin
                    if (pend_q[s] == PMAX) begin
                        ovf_d[s/2] = 1'b1;
                    end else begin
                        pend_d[s] = pend_q[s] + 1'b1;
                    end
                end
            end
            if (grant) begin
                gnt_valid_d = 1'b1;
                gnt_slot_d  = grant_slot;
                ptr_d       = (grant_slot == AW'(NS-1)) ? '0 : grant_slot + 1'b1;
            end
        end

        for (int s = 0; s < NS; s++) begin
            if (pend_d[s] != '0) begin
                busy_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                cnt_q[s]  <= '0;
                pend_q[s] <= '0;
            end
            ovf_q       <= '0;
            prev_q      <= '0;
            primed_q    <= 1'b0;
            ptr_q       <= '0;
            rd_data_q   <= '0;
            gnt_valid_q <= 1'b0;
            gnt_slot_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            for (int s = 0; s < NS; s++) begin
                cnt_q[s]  <= cnt_d[s];
                pend_q[s] <= pend_d[s];
            end
            ovf_q       <= ovf_d;
            prev_q      <= prev_d;
            primed_q    <= primed_d;
            ptr_q       <= ptr_d;
            rd_data_q   <= rd_data_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_slot_q  <= gnt_slot_d;
            busy_q      <= busy_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_slot  = gnt_slot_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

`ifdef SVA_SCHED_ASSERT_EN
    a_gnt_nonzero: assert property (@(posedge clk) disable iff (rst)
        grant |-> (pend_q[grant_slot] != '0))
        else $error("grant issued to empty slot");

    a_hold_no_gnt: assert property (@(posedge clk) disable iff (rst)
        hold |=> !gnt_valid_q)
        else $error("grant issued while hold asserted");

    a_ovf_rise_only: assert property (@(posedge clk) disable iff (rst)
        ($changed(ovf_q) && !$past(clr) && !$past(rst)) |-> ((~ovf_q & $past(ovf_q)) == '0))
        else $error("ovf bit fell without clr");

    for (genvar g = 0; g < NS; g++) begin : g_mono
        a_cnt_mono: assert property (@(posedge clk) disable iff (rst)
            (!$past(clr) && !$past(rst)) |-> (cnt_q[g] >= $past(cnt_q[g])))
            else $error("coverage counter decreased");
    end

    for (genvar g = 0; g < NCH; g++) begin : g_one_ev
        a_one_event: assert property (@(posedge clk) disable iff (rst)
            (primed_q && enable) |-> (ev[2*g] ^ ev[2*g+1]))
            else $error("channel did not produce exactly one event");
    end
`endif

endmodule

// File: tb/tb_sva_cover_count_sched.sv
// tb/tb_sva_cover_count_sched.sv - table-driven and directed bench for sva_cover_count_sched
module tb_sva_cover_count_sched;

    localparam int NCH = 3;
    localparam int CW  = 16;
    localparam int PW  = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           enable;
    logic [NCH-1:0] sig;
    logic           hold;
    logic           clr;
    logic [2:0]     rd_addr;
    logic [CW-1:0]  rd_data;
    logic           gnt_valid;
    logic [2:0]     gnt_slot;
    logic [NCH-1:0] ovf;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    sva_cover_count_sched #(.NCH(NCH), .CW(CW), .PW(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .sig       (sig),
        .hold      (hold),
        .clr       (clr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .gnt_valid (gnt_valid),
        .gnt_slot  (gnt_slot),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic [2:0]  sg;
        logic        hd;
        logic        cl;
        logic [2:0]  addr;
        logic        gv;
        logic [2:0]  gs;
        logic        bz;
        logic [15:0] rd;
    } vec_t;

    vec_t vecs [16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        hold    = 1'b0;
        clr     = 1'b0;
        sig     = '0;
        rst     = 1'b1;
        tick();
        rst     = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        enable = 1'b0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk(name, busy, 0);
    endtask

    task automatic rdchk(input string name, input logic [2:0] a, input logic [15:0] exp);
        rd_addr = a;
        tick();
        chk(name, rd_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int gcount;
        rd_addr = '0;
        do_reset();
        do_reset();
        chk("rst_rd_data", rd_data, 0);
        chk("rst_gnt_valid", gnt_valid, 0);
        chk("rst_gnt_slot", gnt_slot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);

        // en, sig, hold, clr, addr | gv, gs, busy, rd
        vecs[0]  = '{1'b1, 3'b000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 3'b000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0, 1'b1, 16'd0};
        vecs[2]  = '{1'b1, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 3'd1, 1'b1, 16'd0};
        vecs[3]  = '{1'b1, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 3'd3, 1'b1, 16'd1};
        vecs[4]  = '{1'b1, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 3'd5, 1'b1, 16'd1};
        vecs[5]  = '{1'b1, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 3'd1, 1'b1, 16'd1};
        vecs[6]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 3'd3, 1'b1, 16'd4};
        vecs[7]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 3'd5, 1'b1, 16'd4};
        vecs[8]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 1'b1, 3'd1, 1'b0, 16'd4};
        vecs[9]  = '{1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0, 1'b0, 16'd5};
        vecs[10] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'd0};
        vecs[11] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'd1, 1'b0, 3'd0, 1'b0, 16'd5};
        vecs[12] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0, 1'b0, 16'd0};
        vecs[13] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'd3, 1'b0, 3'd0, 1'b0, 16'd5};
        vecs[14] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'd4, 1'b0, 3'd0, 1'b0, 16'd0};
        vecs[15] = '{1'b0, 3'b000, 1'b0, 1'b0, 3'd5, 1'b0, 3'd0, 1'b0, 16'd5};

        // Stable run, round-robin drain and read-back of every slot
        for (int i = 0; i < 16; i++) begin
            enable  = vecs[i].en;
            sig     = vecs[i].sg;
            hold    = vecs[i].hd;
            clr     = vecs[i].cl;
            rd_addr = vecs[i].addr;
            tick();
            chk($sformatf("vec%0d_gnt_valid", i), gnt_valid, vecs[i].gv);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].bz);
            chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].rd);
            if (vecs[i].gv) begin
                chk($sformatf("vec%0d_gnt_slot", i), gnt_slot, vecs[i].gs);
            end
        end
        chk("t1_ovf", ovf, 0);

        // Toggling channel 0 counts changed events only
        do_reset();
        enable = 1'b1;
        sig = 3'b000; tick();
        sig = 3'b001; tick();
        sig = 3'b000; tick();
        sig = 3'b001; tick();
        sig = 3'b000; tick();
        drain("t2_drain");
        rdchk("t2_changed0", 3'd0, 16'd4);
        rdchk("t2_stable0", 3'd1, 16'd0);
        rdchk("t2_changed1", 3'd2, 16'd0);
        rdchk("t2_stable1", 3'd3, 16'd4);
        chk("t2_ovf", ovf, 0);

        // Hold saturates pending and sets sticky ovf
        do_reset();
        hold = 1'b1;
        enable = 1'b1;
        sig = 3'b000;
        gcount = 0;
        for (int i = 0; i < 11; i++) begin
            tick();
            if (gnt_valid) gcount++;
        end
        chk("t3_no_grant_under_hold", gcount, 0);
        chk("t3_ovf_set", ovf, 3'b111);
        chk("t3_busy", busy, 1);
        hold = 1'b0;
        drain("t3_drain");
        rdchk("t3_stable0", 3'd1, 16'd7);
        rdchk("t3_stable2", 3'd5, 16'd7);
        rdchk("t3_changed0", 3'd0, 16'd0);
        chk("t3_ovf_sticky", ovf, 3'b111);

        // clr with counters and pending nonzero; next enabled cycle is a prime
        do_reset();
        enable = 1'b1;
        sig = 3'b000;
        for (int i = 0; i < 4; i++) tick();
        chk("t4_busy_before", busy, 1);
        clr = 1'b1;
        rd_addr = 3'd3;
        tick();
        clr = 1'b0;
        chk("t4_rd_old_in_clr", rd_data, 2);
        chk("t4_busy_after_clr", busy, 0);
        chk("t4_ovf_after_clr", ovf, 0);
        chk("t4_gnt_after_clr", gnt_valid, 0);
        rd_addr = 3'd1;
        tick();
        chk("t4_prime_busy", busy, 0);
        chk("t4_cleared_cnt1", rd_data, 0);
        rd_addr = 3'd3;
        tick();
        chk("t4_event_busy", busy, 1);
        chk("t4_cleared_cnt3", rd_data, 0);
        drain("t4_drain");
        rdchk("t4_stable0_after", 3'd1, 16'd1);

        // Read colliding with a grant, then out-of-range addresses
        do_reset();
        enable = 1'b1;
        sig = 3'b000;
        tick();
        tick();
        enable = 1'b0;
        rd_addr = 3'd1;
        tick();
        chk("t5_collide_old", rd_data, 0);
        chk("t5_gv_a", gnt_valid, 1);
        chk("t5_gs_a", gnt_slot, 1);
        tick();
        chk("t5_collide_new", rd_data, 1);
        chk("t5_gs_b", gnt_slot, 3);
        rd_addr = 3'd7;
        tick();
        chk("t5_oor7", rd_data, 0);
        chk("t5_gs_c", gnt_slot, 5);
        chk("t5_busy_done", busy, 0);
        rdchk("t5_oor6", 3'd6, 16'd0);
        rdchk("t5_slot5", 3'd5, 16'd1);

        // rst mid-drain, then count from zero
        do_reset();
        enable = 1'b1;
        sig = 3'b000;
        for (int i = 0; i < 4; i++) tick();
        enable = 1'b0;
        rd_addr = 3'd3;
        tick();
        chk("t6_busy_mid", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_rd", rd_data, 0);
        chk("t6_rst_gv", gnt_valid, 0);
        chk("t6_rst_gs", gnt_slot, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ovf", ovf, 0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        drain("t6_drain");
        rdchk("t6_stable0", 3'd1, 16'd2);
        rdchk("t6_stable1", 3'd3, 16'd2);
        rdchk("t6_changed0", 3'd0, 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sva_cover_count_sched.md
Name: sva_cover_count_sched

Overview:
Hardware scheduler for sampled-value coverage counting.
- Each clock, samples NCH monitored signals and classifies each channel as $changed or $stable against the previous sample.
- Events are buffered in small per-slot pending counters. A round-robin arbiter grants one shared adder per cycle to fold one pending value into its wide coverage counter.
- A registered read port exposes the counters to the testbench or host.

Parameters:
NCH, 4, number of monitored 1-bit channels
CW, 16, coverage counter width (saturating)
PW, 3, pending counter width (saturating)

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  synchronous, active-high reset
enable  input  1  sampling enable
sig  input  NCH  monitored signals
hold  input  1  suppresses grants (shared-adder backpressure)
clr  input  1  synchronous clear of counters and pending
rd_addr  input  $clog2(2*NCH)  slot index = 2*ch + kind (kind 0 = changed, 1 = stable)
rd_data  output  CW  registered counter value
gnt_valid  output  1  grant issued this cycle (registered)
gnt_slot  output  $clog2(2*NCH)  slot granted (registered)
ovf  output  NCH  sticky pending-overflow flag per channel
busy  output  1  any pending counter nonzero

Behaviour:
- Reset: the already-decided one clock `clk` and synchronous active-high `rst` apply; no async paths. At rst=1 the following are cleared:
  - counters, pending, ovf, rd_data, gnt_valid, gnt_slot, busy: all 0
  - RR pointer: 0
  - primed flag: 0
  - prev sample register: 0
- rst mid-operation discards all pending and counts.
- Sampling:
  - While enable=1, prev <= sig every cycle.
  - First enabled cycle after rst, clr, or enable rising is a prime cycle: it only loads prev and sets primed, and produces no events.
  - While primed and enable=1, each channel produces exactly one event per cycle:
    - changed if sig[i] != prev[i]
    - stable otherwise
  - enable=0 produces no events and clears primed. Arbitration keeps draining.
- Pending update, per slot, per cycle:
  - Granted slot: pending <= ev (0 or 1), counter <= sat(counter + pending).
  - Other slots: pending <= sat(pending + ev).
  - If a pending counter is at 2^PW-1 and receives an event, it stays at 2^PW-1 and sets ovf[ch] (sticky until rst or clr).
- Counter saturation: counters saturate at 2^CW-1 and never wrap.
- Arbiter:
  - When hold=0, the arbiter searches slots ptr, ptr+1, … modulo 2*NCH for the first slot with nonzero pending (pre-update value).
  - If one is found, it is granted and ptr <= granted slot + 1 (wraps).
  - If none is found, or hold=1, there is no grant and ptr is unchanged.
  - At most one grant per cycle.
- gnt_valid and gnt_slot are registered, appearing the cycle after the update.
- busy is registered; it is 1 when any pending value after update is nonzero.
- Read: rd_data <= counter[rd_addr] using the pre-update value, giving 1-cycle latency. A read colliding with a grant to the same slot returns the old value. rd_addr ≥ 2*NCH returns 0.
- clr:
  - Priority: rst > clr > grant/events.
  - Clears counters, pending, ovf, ptr, and primed.
  - Events in the clr cycle are dropped.
  - rd_data in the cycle after clr reads the old counter value.
- No lost events while pending is unsaturated. The total added to counters equals the total events, minus events dropped at pending saturation.

Optional Feature:
SVA_SCHED_ASSERT_EN
- Defined: compiles in concurrent assertions clocked on posedge clk, disabled iff rst:
  - gnt_valid implies pending of gnt_slot was nonzero
  - counters never decrease except on clr
  - $changed(ovf) implies rose only
  - hold=1 implies next-cycle gnt_valid=0
  - for each channel when primed, exactly one of its two slots receives an event
- Failures call $error.
- Undefined: no assertion code. Functional behaviour is identical in both builds.

Test Plan:
1. NCH=2; rst, then enable=1 with sig=00 for 6 cycles, enable=0, wait until busy=0 -> stable[0]=stable[1]=5, changed[0]=changed[1]=0, ovf=0.
2. Prime with sig[0]=0, then sig[0]=1,0,1,0 on consecutive cycles, enable=0, drain -> changed[0]=4, stable[0]=0.
3. hold=1, enable=1, sig constant for 1 prime + 10 cycles, then enable=0, hold=0, drain -> stable[0]=7, ovf[0]=1, no grant while hold=1.
4. Counters nonzero and pending nonzero, pulse clr for 1 cycle -> next cycle all counters read 0, ovf=0, busy=0; the first enabled cycle after clr is a prime cycle with no event.
5. rd_addr targeting a slot granted in the same cycle -> rd_data shows the old value, and the new value on the next read; rd_addr=2*NCH -> rd_data=0.
6. rst asserted mid-drain with busy=1 -> next cycle all outputs 0; a subsequent stable run counts from 0.
